// File: rtl/mcycle_flag_unit.sv
// Multi-cycle multiply/divide unit producing results with NZCV flags and FlagW.
// Optional MCYCLE_EARLY_TERM_EN: multiply finishes once remaining multiplier is zero.
module mcycle_flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic             S,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       ALUFlags,
    output logic [1:0]       FlagW
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic               s_q, neg_q, rneg_q, div0_q, ovf_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier, rem, quo, dvs;

    logic               accept, last, sgn_in, is_div;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH-1:0] mul_add, prod;
    logic [WIDTH-1:0]   mplier_nx, rem_nx, quo_nx, quo_f, rem_f;
    logic [WIDTH:0]     rem_sh, diff;
    logic [WIDTH-1:0]   res1, res2;
    logic [3:0]         flags;

    assign accept = Start && (state != COMPUTE);
    assign sgn_in = ~MCycleOp[0];
    assign is_div = op_q[1];
    assign mag1   = (sgn_in && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
    assign mag2   = (sgn_in && Operand2[WIDTH-1]) ? -Operand2 : Operand2;

    // One iteration of each core, evaluated from the current state
    assign mul_add   = mplier[0] ? acc + mcand : acc;
    assign mplier_nx = mplier >> 1;
    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvs};
    assign rem_nx    = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nx    = {quo[WIDTH-2:0], ~diff[WIDTH]};

`ifdef MCYCLE_EARLY_TERM_EN
    assign last = (cnt == CW'(WIDTH-1)) || (!is_div && (mplier_nx == '0));
`else
    assign last = (cnt == CW'(WIDTH-1));
`endif

    assign prod  = neg_q ? -mul_add : mul_add;
    assign quo_f = neg_q ? -quo_nx : quo_nx;
    assign rem_f = rneg_q ? -rem_nx : rem_nx;

    always_comb begin
        res1  = prod[WIDTH-1:0];
        res2  = prod[2*WIDTH-1:WIDTH];
        flags = {res2[WIDTH-1], prod == '0, 2'b00};
        if (is_div) begin
            res1  = quo_f;
            res2  = rem_f;
            flags = 4'b0000;
            if (div0_q) begin
                res1     = '1;
                res2     = a_q;
                flags[0] = 1'b1;
            end else if (ovf_q) begin
                res1     = MIN;
                res2     = '0;
                flags[0] = 1'b1;
            end
            flags[3] = res1[WIDTH-1];
            flags[2] = (res1 == '0);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (Start) state_nx = COMPUTE;
            COMPUTE: if (last) state_nx = DONE;
            DONE:    state_nx = Start ? COMPUTE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy  = accept || (state == COMPUTE);
        Done  = (state == DONE);
        FlagW = (Done && s_q) ? 2'b11 : 2'b00;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt      <= '0;
            op_q     <= '0;
            s_q      <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            Result1  <= '0;
            Result2  <= '0;
            ALUFlags <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= MCycleOp;
            s_q    <= S;
            neg_q  <= sgn_in && (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
            rneg_q <= sgn_in && Operand1[WIDTH-1];
            div0_q <= (Operand2 == '0);
            ovf_q  <= sgn_in && MCycleOp[1] && (Operand1 == MIN) && (Operand2 == '1);
            a_q    <= Operand1;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag1};
            mplier <= mag2;
            rem    <= '0;
            quo    <= mag1;
            dvs    <= mag2;
        end else if (state == COMPUTE) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                rem <= rem_nx;
                quo <= quo_nx;
            end else begin
                acc    <= mul_add;
                mcand  <= mcand << 1;
                mplier <= mplier_nx;
            end
            if (last) begin
                Result1  <= res1;
                Result2  <= res2;
                ALUFlags <= flags;
            end
        end
    end
endmodule

// File: tb/tb_mcycle_flag_unit.sv
// Scoreboard bench for mcycle_flag_unit: stimulus pushes model results,
// a negedge monitor pops and compares on every Done pulse.
module tb_mcycle_flag_unit;
    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          Start = 1'b0;
    logic [1:0]    MCycleOp = 2'b00;
    logic          S = 1'b0;
    logic [W-1:0]  Operand1 = '0;
    logic [W-1:0]  Operand2 = '0;
    logic [W-1:0]  Result1, Result2;
    logic          Busy, Done;
    logic [3:0]    ALUFlags;
    logic [1:0]    FlagW;

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [3:0]   f;
        logic [1:0]   fw;
        int unsigned  dc;
    } exp_t;

    exp_t sb[$];
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    mcycle_flag_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .S(S), .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done),
        .ALUFlags(ALUFlags), .FlagW(FlagW)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Reference: plain arithmetic on the architectural operands
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic s);
        exp_t e;
        longint sa, sb_;
        logic [63:0] p, ua, ub;
        int ia, ib;
        e.f = 4'b0000;
        e.fw = s ? 2'b11 : 2'b00;
        e.dc = 0;
        if (!op[1]) begin
            if (op == 2'b00) begin
                sa = longint'($signed(a));
                sb_ = longint'($signed(b));
                p = 64'(sa * sb_);
            end else begin
                ua = {32'b0, a};
                ub = {32'b0, b};
                p = ua * ub;
            end
            e.r1 = p[31:0];
            e.r2 = p[63:32];
            e.f[3] = p[63];
            e.f[2] = (p == 64'd0);
        end else begin
            if (b == 0) begin
                e.r1 = '1;
                e.r2 = a;
                e.f[0] = 1'b1;
            end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.r1 = 32'h8000_0000;
                e.r2 = '0;
                e.f[0] = 1'b1;
            end else if (op == 2'b10) begin
                ia = $signed(a);
                ib = $signed(b);
                e.r1 = ia / ib;
                e.r2 = ia % ib;
            end else begin
                e.r1 = a / b;
                e.r2 = a % b;
            end
            e.f[3] = e.r1[31];
            e.f[2] = (e.r1 == 0);
        end
        return e;
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [W-1:0] b);
        int l;
        logic [W-1:0] mg;
        l = W;
`ifdef MCYCLE_EARLY_TERM_EN
        if (!op[1]) begin
            mg = (op == 2'b00 && b[31]) ? -b : b;
            l = 1;
            while (l < W && (mg >> l) != 0) l++;
        end
`else
        mg = b;
        if (op[1] && mg[0] === 1'bx) l = 0;
`endif
        return l;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s, input bit push,
                         input bit hold);
        exp_t e;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        S = s;
        Start = 1'b1;
        #1;
        chk("busy_on_start", 64'(Busy), 64'd1);
        if (push) begin
            e = model(op, a, b, s);
            e.dc = cyc + 1 + latency(op, b);
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        if (hold) begin
            for (int i = 0; i < W - 3; i++) begin
                MCycleOp = 2'($urandom);
                Operand1 = $urandom;
                Operand2 = $urandom;
                S = 1'($urandom);
                @(posedge CLK);
                #1;
            end
        end
        Start = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = 2'($urandom);
        S = 1'($urandom);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < W + 5; i++) begin
            if (Done) begin
                seen = 1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no Done want Done");
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s);
        issue(op, a, b, s, 1'b1, 1'b0);
        wait_done();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_r1"}, 64'(Result1), 64'd0);
        chk({tag, "_r2"}, 64'(Result2), 64'd0);
        chk({tag, "_busy"}, 64'(Busy), 64'd0);
        chk({tag, "_done"}, 64'(Done), 64'd0);
        chk({tag, "_flags"}, 64'(ALUFlags), 64'd0);
        chk({tag, "_flagw"}, 64'(FlagW), 64'd0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && Done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got Done want none");
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.dc));
                chk("result1", 64'(Result1), 64'(e.r1));
                chk("result2", 64'(Result2), 64'(e.r2));
                chk("aluflags", 64'(ALUFlags), 64'(e.f));
                chk("flagw", 64'(FlagW), 64'(e.fw));
                chk("busy_in_done", 64'(Busy), 64'(Start));
            end
        end
    end

    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    initial begin
        #3;
        chk_zero("reset");
        @(negedge CLK);
        RESET = 1'b0;

        run(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run(2'b00, -32'sd3, 32'd5, 1'b1);
        run(2'b10, -32'sd7, 32'd2, 1'b0);
        run(2'b11, 32'd5, 32'd0, 1'b1);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(2'b01, 32'd0, 32'd7, 1'b0);
        run(2'b01, 32'd9, 32'd3, 1'b0);
        run(2'b01, 32'd9, 32'd0, 1'b1);
        repeat (2) @(posedge CLK);
        #1;

        // Abort an operation mid-flight with an asynchronous reset
        issue(2'b01, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        repeat (9) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk_zero("midreset");
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("no_done_after_reset", 64'(Done), 64'd0);

        // Start held high while computing must not restart or change operands
        issue(2'b11, 32'd1000, 32'd7, 1'b1, 1'b1, 1'b1);
        wait_done();

        for (int k = 0; k < 150; k++) begin
            rop = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(0, 15));
                4: ra = 0;
                default: ;
            endcase
            run(rop, ra, rb, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
        end

        @(negedge CLK);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
